// File: rtl/counter_updown_mod.sv
// counter_updown_mod: modulo-MODULUS up/down counter with synchronous load, wrap or saturate
// at the range ends, terminal-count and wrap flags. Define COUNTER_PRESCALE_EN to build the step prescaler.
module counter_updown_mod #(
   parameter int BITS     = 32'sd4,
   parameter int MODULUS  = 32'sd16,
   parameter int SATURATE = 32'sd0,
   parameter int PRESCALE = 32'sd4
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            en,
   input  logic            select,
   input  logic            load,
   input  logic [BITS-1:0] load_val,
   output logic [BITS-1:0] count,
   output logic            tc,
   output logic            wrap
);

   // MODULUS-1 is formed in 32-bit arithmetic so MODULUS == 2**BITS cannot overflow
   localparam logic [BITS-1:0] max_c  = BITS'(MODULUS - 32'sd1);
   localparam logic [BITS-1:0] zero_c = {BITS{1'b0}};
   localparam logic [BITS-1:0] one_c  = BITS'(32'd1);
   localparam bit              sat_c  = (SATURATE != 32'sd0);

   logic [BITS-1:0] count_r;
   logic [BITS-1:0] count_nxt_s;
   logic            wrap_r;
   logic            wrap_nxt_s;
   logic            step_s;

`ifdef COUNTER_PRESCALE_EN
   localparam int              pw_c       = (PRESCALE > 32'sd1) ? $clog2(PRESCALE) : 32'sd1;
   localparam logic [pw_c-1:0] pre_last_c = pw_c'(PRESCALE - 32'sd1);
   localparam logic [pw_c-1:0] pre_zero_c = {pw_c{1'b0}};
   localparam logic [pw_c-1:0] pre_one_c  = pw_c'(32'd1);

   logic [pw_c-1:0] pre_r;

   // Prescaler: counts enabled edges, frozen while en is low, restarted by load
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pre_r <= pre_zero_c;
      end else if (load) begin
         pre_r <= pre_zero_c;
      end else if (en) begin
         if (pre_r == pre_last_c) begin
            pre_r <= pre_zero_c;
         end else begin
            pre_r <= pre_r + pre_one_c;
         end
      end else begin
         pre_r <= pre_r;
      end
   end

   assign step_s = en & (pre_r == pre_last_c);
`else
   localparam int unused_prescale_c = PRESCALE;

   assign step_s = en;
`endif

   // Next count and wrap: load beats step, step beats hold
   always_comb begin
      count_nxt_s = count_r;
      wrap_nxt_s  = 1'b0;
      if (load) begin
         if (load_val > max_c) begin
            count_nxt_s = max_c;
         end else begin
            count_nxt_s = load_val;
         end
      end else if (step_s) begin
         case (select)
            1'b0: begin
               if (count_r < max_c) begin
                  count_nxt_s = count_r + one_c;
               end else if (!sat_c) begin
                  count_nxt_s = zero_c;
                  wrap_nxt_s  = 1'b1;
               end else begin
                  count_nxt_s = count_r;
               end
            end
            1'b1: begin
               if (count_r > zero_c) begin
                  count_nxt_s = count_r - one_c;
               end else if (!sat_c) begin
                  count_nxt_s = max_c;
                  wrap_nxt_s  = 1'b1;
               end else begin
                  count_nxt_s = count_r;
               end
            end
            default: begin
               count_nxt_s = count_r;
            end
         endcase
      end else begin
         count_nxt_s = count_r;
      end
   end

   // Count and wrap registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_r <= zero_c;
         wrap_r  <= 1'b0;
      end else begin
         count_r <= count_nxt_s;
         wrap_r  <= wrap_nxt_s;
      end
   end

   assign count = count_r;
   assign wrap  = wrap_r;
   // tc follows select combinationally so a direction change is seen without a clock edge
   assign tc    = select ? (count_r == zero_c) : (count_r == max_c);

endmodule

// File: tb/tb_counter_updown_mod.sv
// Bench for counter_updown_mod: three instances (mod-10 wrap, mod-10 saturate, mod-16 wrap)
// checked against a vector table, hand sequences and a random run against an arithmetic model.
module tb_counter_updown_mod;

`ifdef COUNTER_PRESCALE_EN
   localparam int ps_c = 4;
`else
   localparam int ps_c = 1;
`endif

   logic       clk = 1'b0;
   logic       rst_n;
   logic       en;
   logic       sel;
   logic       ld;
   logic [3:0] lv;
   logic [3:0] cnt_o [3];
   logic       tc_o  [3];
   logic       wr_o  [3];

   int n_chk  = 0;
   int n_fail = 0;

   // model state, one entry per instance
   int md [3];
   int sa [3];
   int mc [3];
   int mw [3];
   int mp;

   typedef struct {
      bit       ld;
      bit       en;
      bit       sel;
      bit [3:0] lv;
      int       cnt;
      int       tc;
      int       wr;
   } vec_t;
   vec_t vecs[$];

   always #5 clk = ~clk;

   counter_updown_mod #(.BITS(4), .MODULUS(10), .SATURATE(0), .PRESCALE(4)) dut_a (
      .clk(clk), .rst_n(rst_n), .en(en), .select(sel), .load(ld), .load_val(lv),
      .count(cnt_o[0]), .tc(tc_o[0]), .wrap(wr_o[0]));
   counter_updown_mod #(.BITS(4), .MODULUS(10), .SATURATE(1), .PRESCALE(4)) dut_b (
      .clk(clk), .rst_n(rst_n), .en(en), .select(sel), .load(ld), .load_val(lv),
      .count(cnt_o[1]), .tc(tc_o[1]), .wrap(wr_o[1]));
   counter_updown_mod #(.BITS(4), .MODULUS(16), .SATURATE(0), .PRESCALE(4)) dut_c (
      .clk(clk), .rst_n(rst_n), .en(en), .select(sel), .load(ld), .load_val(lv),
      .count(cnt_o[2]), .tc(tc_o[2]), .wrap(wr_o[2]));

   task automatic chk(input string nm, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int k = 0; k < 3; k++) begin
         mc[k] = 0;
         mw[k] = 0;
      end
      mp = 0;
   endtask

   // One clock edge of the spec rules, applied with plain modular arithmetic
   task automatic model_step();
      bit stp;
      stp = 1'b0;
      if (ld) begin
         mp = 0;
      end else if (en) begin
         if (mp == ps_c - 1) begin
            mp = 0;
            stp = 1'b1;
         end else begin
            mp++;
         end
      end
      for (int k = 0; k < 3; k++) begin
         mw[k] = 0;
         if (ld) begin
            mc[k] = (int'(lv) > md[k] - 1) ? md[k] - 1 : int'(lv);
         end else if (stp) begin
            if (!sel && mc[k] == md[k] - 1) begin
               if (sa[k] == 0) begin mc[k] = 0; mw[k] = 1; end
            end else if (sel && mc[k] == 0) begin
               if (sa[k] == 0) begin mc[k] = md[k] - 1; mw[k] = 1; end
            end else begin
               mc[k] = sel ? mc[k] - 1 : mc[k] + 1;
            end
         end
      end
   endtask

   task automatic check_model(input string tag);
      for (int k = 0; k < 3; k++) begin
         chk($sformatf("%s.count[%0d]", tag, k), int'(cnt_o[k]), mc[k]);
         chk($sformatf("%s.wrap[%0d]", tag, k), int'(wr_o[k]), mw[k]);
         chk($sformatf("%s.tc[%0d]", tag, k), int'(tc_o[k]),
             (sel ? (mc[k] == 0) : (mc[k] == md[k] - 1)) ? 1 : 0);
      end
   endtask

   task automatic tick(input string tag);
      @(posedge clk);
      #1;
      model_step();
      check_model(tag);
   endtask

   task automatic drive(input bit l, input bit e, input bit s, input bit [3:0] v);
      ld  = l;
      en  = e;
      sel = s;
      lv  = v;
   endtask

   task automatic add(input bit l, input bit e, input bit s, input bit [3:0] v,
                      input int c, input int t, input int w);
      vec_t x;
      x.ld = l; x.en = e; x.sel = s; x.lv = v; x.cnt = c; x.tc = t; x.wr = w;
      vecs.push_back(x);
   endtask

   initial begin
      md[0] = 10; md[1] = 10; md[2] = 16;
      sa[0] = 0;  sa[1] = 1;  sa[2] = 0;
      model_reset();
      rst_n = 1'b0;
      drive(1'b0, 1'b0, 1'b0, 4'd0);
      #3;
      for (int k = 0; k < 3; k++) begin
         chk($sformatf("reset.count[%0d]", k), int'(cnt_o[k]), 0);
         chk($sformatf("reset.wrap[%0d]", k), int'(wr_o[k]), 0);
      end
      chk("reset.tc_a", int'(tc_o[0]), 0);
      #4 rst_n = 1'b1;

`ifndef COUNTER_PRESCALE_EN
      // count up through the wrap, load, count down through the wrap, clamp, load beats en
      for (int i = 1; i <= 10; i++) add(1'b0, 1'b1, 1'b0, 4'd0, i % 10, (i == 9) ? 1 : 0, (i == 10) ? 1 : 0);
      add(1'b1, 1'b0, 1'b1, 4'd3, 3, 0, 0);
      add(1'b0, 1'b1, 1'b1, 4'd0, 2, 0, 0);
      add(1'b0, 1'b1, 1'b1, 4'd0, 1, 0, 0);
      add(1'b0, 1'b1, 1'b1, 4'd0, 0, 1, 0);
      add(1'b0, 1'b1, 1'b1, 4'd0, 9, 0, 1);
      add(1'b1, 1'b0, 1'b0, 4'd12, 9, 1, 0);
      add(1'b1, 1'b1, 1'b0, 4'd4, 4, 0, 0);
      add(1'b0, 1'b0, 1'b0, 4'd0, 4, 0, 0);
      add(1'b0, 1'b0, 1'b1, 4'd0, 4, 0, 0);
      foreach (vecs[i]) begin
         drive(vecs[i].ld, vecs[i].en, vecs[i].sel, vecs[i].lv);
         tick("vec");
         chk($sformatf("vec%0d.count", i), int'(cnt_o[0]), vecs[i].cnt);
         chk($sformatf("vec%0d.tc", i), int'(tc_o[0]), vecs[i].tc);
         chk($sformatf("vec%0d.wrap", i), int'(wr_o[0]), vecs[i].wr);
      end

      // saturating instance holds at both ends with no wrap pulse
      drive(1'b1, 1'b0, 1'b0, 4'd8);
      tick("sat_ld8");
      drive(1'b0, 1'b1, 1'b0, 4'd0);
      for (int i = 0; i < 3; i++) begin
         tick("sat_up");
         chk("sat_up.count_b", int'(cnt_o[1]), 9);
         chk("sat_up.wrap_b", int'(wr_o[1]), 0);
      end
      drive(1'b1, 1'b0, 1'b1, 4'd1);
      tick("sat_ld1");
      drive(1'b0, 1'b1, 1'b1, 4'd0);
      for (int i = 0; i < 2; i++) begin
         tick("sat_dn");
         chk("sat_dn.count_b", int'(cnt_o[1]), 0);
      end
`else
      // prescaled stepping, en-low freeze and load restarting the interval
      drive(1'b0, 1'b1, 1'b0, 4'd0);
      for (int i = 1; i <= 8; i++) begin
         tick("pre_run");
         chk("pre_run.count_a", int'(cnt_o[0]), i / 4);
      end
      tick("pre_a"); tick("pre_b");
      drive(1'b0, 1'b0, 1'b0, 4'd0);
      tick("pre_hold"); tick("pre_hold");
      drive(1'b0, 1'b1, 1'b0, 4'd0);
      tick("pre_c");
      chk("pre_c.count_a", int'(cnt_o[0]), 2);
      tick("pre_d");
      chk("pre_d.count_a", int'(cnt_o[0]), 3);
      tick("pre_e");
      drive(1'b1, 1'b0, 1'b0, 4'd5);
      tick("pre_ld");
      drive(1'b0, 1'b1, 1'b0, 4'd0);
      for (int i = 1; i <= 4; i++) begin
         tick("pre_restart");
         chk("pre_restart.count_a", int'(cnt_o[0]), (i == 4) ? 6 : 5);
      end
`endif

      // tc follows select between clock edges
      drive(1'b1, 1'b0, 1'b0, 4'd9);
      tick("tcsel_ld");
      chk("tcsel.up_at9", int'(tc_o[0]), 1);
      #1 sel = 1'b1;
      #1 chk("tcsel.down_at9", int'(tc_o[0]), 0);
      ld = 1'b0;
      tick("tcsel_hold");

      // asynchronous reset between edges at count 6, and while wrap is high
      drive(1'b1, 1'b0, 1'b0, 4'd6);
      tick("arst_ld6");
      #1 rst_n = 1'b0;
      #1 chk("arst6.count_a", int'(cnt_o[0]), 0);
      chk("arst6.wrap_a", int'(wr_o[0]), 0);
      model_reset();
      rst_n = 1'b1;
      drive(1'b0, 1'b1, 1'b1, 4'd0);
      tick("arst_wrap");
      chk("arst_wrap.wrap_a", int'(wr_o[0]), (ps_c == 1) ? 1 : 0);
      #1 rst_n = 1'b0;
      #1 chk("arst_wrap.count_a", int'(cnt_o[0]), 0);
      chk("arst_wrap.wrap_a_clr", int'(wr_o[0]), 0);
      model_reset();
      rst_n = 1'b1;

      // randomized traffic against the model
      for (int i = 0; i < 400; i++) begin
         drive(($urandom_range(7) == 0), ($urandom_range(3) != 0),
               ($urandom_range(15) == 0) ? ~sel : sel, 4'($urandom_range(15)));
         tick("rand");
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
